tx_controller: RTL and testbench
================================

TX_CONTROLLER -- requirements
Module: tx_controller

Interface
REQ-001 Parameter BAUD_DIV, default 868: tx_clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts a parity bit between data and stop.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
REQ-004 Port tx_clk, input, 1, single clock for all logic.
REQ-005 Port tx_rst_n, input, 1, reset; synchronous, active-low.
REQ-006 Port tx_start, input, 1, request to transmit tx_data.
REQ-007 Port tx_data, input, 8, byte to send; sampled only on acceptance.
REQ-008 Port tx_out, output, 1, serial line; idle high.
REQ-009 Port tx_busy, output, 1, frame in progress.
REQ-010 Port tx_done, output, 1, one-cycle pulse at frame end.
REQ-011 Port bit_select, output, 4, index of the bit currently on tx_out.

Function
REQ-012 FSM states: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-013 Acceptance: on a tx_clk edge in IDLE with tx_start=1, the controller SHALL latch tx_data, enter START, drive tx_out=0 and tx_busy=1 from that edge.
REQ-014 tx_start SHALL be ignored in every state except IDLE; the latched byte SHALL not change mid-frame.
REQ-015 Each of START, every DATA bit, PARITY and STOP SHALL last exactly BAUD_DIV cycles.
REQ-016 Bit timing uses an internal baud counter of width clog2(BAUD_DIV) that SHALL count 0..BAUD_DIV-1, wrap to 0, and be cleared on acceptance.
REQ-017 DATA SHALL send the latched byte LSB first, advancing one bit per baud-counter wrap.
REQ-018 Parity bit SHALL be the XOR of the 8 data bits for even parity, and its inverse for odd parity.
REQ-019 STOP SHALL drive tx_out=1.
REQ-020 bit_select SHALL be 0 in IDLE and START, 1..8 for data bits 0..7, 9 for PARITY or STOP, and 10 for STOP when PARITY_EN=1.
REQ-021 Frame length is FRAME_WIDTH = 10 + PARITY_EN bits; tx_busy SHALL stay high for exactly FRAME_WIDTH*BAUD_DIV cycles.
REQ-022 At the last STOP cycle's edge the controller SHALL return to IDLE, drive tx_busy=0, and pulse tx_done=1 for one cycle.
REQ-023 tx_start=1 in the tx_done cycle SHALL be accepted, giving exactly one idle-high cycle between back-to-back frames.
REQ-024 In IDLE, tx_out SHALL be 1 and tx_done 0 except in the single pulse cycle.
REQ-025 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-026 tx_rst_n=0 at a tx_clk edge SHALL force state=IDLE, tx_out=1, tx_busy=0, tx_done=0, bit_select=0, baud counter=0, latched byte=0.
REQ-027 Reset mid-frame SHALL abort the frame without a tx_done pulse; tx_start is ignored while tx_rst_n=0.

Structure
REQ-028 Package uart_tx_pkg SHALL hold the state enumeration, DATA_WIDTH=8, and the bit_select index constants.
REQ-029 Baud timing SHALL be a sub-module tx_baud_gen (counter plus wrap tick, clear input); the FSM, shift and parity logic stay in tx_controller.

Verification (BAUD_DIV=4 unless stated)
REQ-030 Reset: hold tx_rst_n=0 for 3 cycles with tx_start=1 -> tx_out=1, tx_busy=0, tx_done=0, bit_select=0 throughout.
REQ-031 Send 0xA5 with PARITY_EN=0 -> tx_out per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1; tx_busy high for 40 cycles; tx_done pulses once in cycle 41.
REQ-032 Pulse tx_start with tx_data=0xFF during DATA of an 0xA5 frame -> waveform identical to REQ-031.
REQ-033 Hold tx_start=1 with 0x00 then 0x55 -> second START begins one cycle after first tx_done; exactly one idle-high cycle between frames.
REQ-034 PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit=1; bit_select reaches 10; tx_busy high for 44 cycles.
REQ-035 Assert tx_rst_n=0 during data bit 3 -> next cycle tx_out=1, tx_busy=0; no tx_done pulse; next tx_start gives a full frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM states, data width,
// bit_select index values and the parity helper.
package uart_tx_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned IDX_W      = $clog2(DATA_WIDTH);
    localparam int unsigned SEL_W      = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // bit_select values: the frame position of the bit currently on the line
    localparam logic [SEL_W-1:0] SEL_IDLE     = 4'd0;
    localparam logic [SEL_W-1:0] SEL_START    = 4'd0;
    localparam logic [SEL_W-1:0] SEL_DATA0    = 4'd1;
    localparam logic [SEL_W-1:0] SEL_PARITY   = 4'd9;
    localparam logic [SEL_W-1:0] SEL_STOP     = 4'd9;
    localparam logic [SEL_W-1:0] SEL_STOP_PAR = 4'd10;

    // Even parity is the XOR of the data bits; odd parity is its inverse
    function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] data,
                                        input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/tx_baud_gen.sv
// Baud timer: counts 0..BAUD_DIV-1 while enabled and flags the last cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : restart the count at 0 (frame acceptance)
//   enable     : count while a frame is in progress
//   tick_c     : high in the last cycle of a bit period (combinational)
module tx_baud_gen #(
    parameter int unsigned BAUD_DIV = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] count;

    // Bit-period counter; wraps to 0 after LAST
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign tick_c = enable && (count == LAST);

endmodule

// File: rtl/tx_controller.sv
// UART transmit controller: frames a latched byte as start, 8 data bits
// (LSB first), optional parity and stop, each lasting BAUD_DIV cycles.
// Ports:
//   tx_clk, tx_rst_n : clock, synchronous active-low reset
//   tx_start         : transmit request, honoured only in IDLE
//   tx_data          : byte to send, latched on acceptance
//   tx_out           : serial line, idle high
//   tx_busy          : frame in progress
//   tx_done          : one-cycle pulse when the frame ends
//   bit_select       : frame position of the bit on tx_out
module tx_controller
    import uart_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                  tx_clk,
    input  logic                  tx_rst_n,
    input  logic                  tx_start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_out,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic [SEL_W-1:0]      bit_select
);

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] data_q, data_n;
    logic [IDX_W-1:0]      idx_q, idx_n;
    logic                  out_n, busy_n, done_n;
    logic [SEL_W-1:0]      sel_n;
    logic                  accept_c;
    logic                  tick_c;

    tx_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk    (tx_clk),
        .rst_n  (tx_rst_n),
        .clear  (accept_c),
        .enable (tx_busy),
        .tick_c (tick_c)
    );

    // State, latched byte and registered outputs
    always_ff @(posedge tx_clk) begin
        if (!tx_rst_n) begin
            state      <= IDLE;
            data_q     <= '0;
            idx_q      <= '0;
            tx_out     <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            bit_select <= SEL_IDLE;
        end else begin
            state      <= state_n;
            data_q     <= data_n;
            idx_q      <= idx_n;
            tx_out     <= out_n;
            tx_busy    <= busy_n;
            tx_done    <= done_n;
            bit_select <= sel_n;
        end
    end

    // Next state and next output values; transitions happen on baud wraps
    always_comb begin
        state_n  = state;
        data_n   = data_q;
        idx_n    = idx_q;
        out_n    = tx_out;
        busy_n   = tx_busy;
        done_n   = 1'b0;
        sel_n    = bit_select;
        accept_c = 1'b0;

        case (state)
            IDLE: begin
                out_n  = 1'b1;
                busy_n = 1'b0;
                sel_n  = SEL_IDLE;
                if (tx_start) begin
                    accept_c = 1'b1;
                    data_n   = tx_data;
                    state_n  = START;
                    out_n    = 1'b0;
                    busy_n   = 1'b1;
                    sel_n    = SEL_START;
                end
            end
            START: begin
                if (tick_c) begin
                    state_n = DATA;
                    idx_n   = '0;
                    out_n   = data_q[0];
                    sel_n   = SEL_DATA0;
                end
            end
            DATA: begin
                if (tick_c) begin
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            out_n   = parity_bit(data_q, PARITY_ODD != 0);
                            sel_n   = SEL_PARITY;
                        end else begin
                            state_n = STOP;
                            out_n   = 1'b1;
                            sel_n   = SEL_STOP;
                        end
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                        out_n = data_q[idx_n];
                        sel_n = SEL_DATA0 + SEL_W'(idx_n);
                    end
                end
            end
            PARITY: begin
                if (tick_c) begin
                    state_n = STOP;
                    out_n   = 1'b1;
                    sel_n   = SEL_STOP_PAR;
                end
            end
            STOP: begin
                if (tick_c) begin
                    state_n = IDLE;
                    out_n   = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    sel_n   = SEL_IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                out_n   = 1'b1;
                busy_n  = 1'b0;
                sel_n   = SEL_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_controller.sv
// Directed bench for tx_controller: one instance without parity, one with
// even parity, both at BAUD_DIV=4. Frames are listed bit by bit as sent.
module tb_tx_controller;

    localparam int unsigned BAUD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, start1;
    logic [7:0] data0, data1;
    logic       out0, busy0, done0;
    logic       out1, busy1, done1;
    logic [3:0] sel0, sel1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tx_controller #(
        .BAUD_DIV   (BAUD),
        .PARITY_EN  (0),
        .PARITY_ODD (0)
    ) u_dut0 (
        .tx_clk     (clk),
        .tx_rst_n   (rst_n),
        .tx_start   (start0),
        .tx_data    (data0),
        .tx_out     (out0),
        .tx_busy    (busy0),
        .tx_done    (done0),
        .bit_select (sel0)
    );

    tx_controller #(
        .BAUD_DIV   (BAUD),
        .PARITY_EN  (1),
        .PARITY_ODD (0)
    ) u_dut1 (
        .tx_clk     (clk),
        .tx_rst_n   (rst_n),
        .tx_start   (start1),
        .tx_data    (data1),
        .tx_out     (out1),
        .tx_busy    (busy1),
        .tx_done    (done1),
        .bit_select (sel1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input int which, input logic s, input logic [7:0] d);
        if (which == 0) begin
            start0 = s;
            data0  = d;
        end else begin
            start1 = s;
            data1  = d;
        end
    endtask

    task automatic check_outs(input int which, input string tag, input logic o,
                              input logic b, input logic d, input logic [3:0] s);
        check({tag, "_out"},  32'(which == 0 ? out0  : out1),  32'(o));
        check({tag, "_busy"}, 32'(which == 0 ? busy0 : busy1), 32'(b));
        check({tag, "_done"}, 32'(which == 0 ? done0 : done1), 32'(d));
        check({tag, "_sel"},  32'(which == 0 ? sel0  : sel1),  32'(s));
    endtask

    // Called at the sample of the first busy cycle; returns at the tx_done sample.
    task automatic check_frame(input int which, input string name, input logic [0:10] bits,
                               input int nbits, input int glitch_k, input logic hold,
                               input logic [7:0] hold_data);
        for (int k = 0; k < nbits * int'(BAUD); k++) begin
            check_outs(which, $sformatf("%s_k%0d", name, k), bits[k / int'(BAUD)],
                       1'b1, 1'b0, 4'(k / int'(BAUD)));
            if (hold)               drive(which, 1'b1, hold_data);
            else if (k == glitch_k) drive(which, 1'b1, 8'hFF);
            else                    drive(which, 1'b0, 8'h00);
            @(negedge clk);
        end
        check_outs(which, {name, "_end"}, 1'b1, 1'b0, 1'b1, 4'd0);
    endtask

    logic [0:10] f_a5, f_00, f_55, f_07p;

    initial begin
        f_a5  = 11'b0101_0010_110;
        f_00  = 11'b0000_0000_010;
        f_55  = 11'b0101_0101_010;
        f_07p = 11'b0111_0000_011;

        // Reset held with tx_start asserted
        rst_n = 1'b0;
        drive(0, 1'b1, 8'h3C);
        drive(1, 1'b1, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outs(0, $sformatf("rst0_%0d", i), 1'b1, 1'b0, 1'b0, 4'd0);
            check_outs(1, $sformatf("rst1_%0d", i), 1'b1, 1'b0, 1'b0, 4'd0);
        end
        rst_n = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        @(negedge clk);
        check_outs(0, "idle0", 1'b1, 1'b0, 1'b0, 4'd0);

        // Plain 0xA5 frame
        drive(0, 1'b1, 8'hA5);
        @(negedge clk);
        check_frame(0, "a5", f_a5, 10, -1, 1'b0, 8'h00);
        @(negedge clk);
        check_outs(0, "a5_post", 1'b1, 1'b0, 1'b0, 4'd0);

        // tx_start with 0xFF pulsed during data bit 2 must not disturb the frame
        drive(0, 1'b1, 8'hA5);
        @(negedge clk);
        check_frame(0, "a5g", f_a5, 10, 14, 1'b0, 8'h00);
        @(negedge clk);
        check_outs(0, "a5g_post", 1'b1, 1'b0, 1'b0, 4'd0);

        // Back-to-back: tx_start held, second byte accepted in the tx_done cycle
        drive(0, 1'b1, 8'h00);
        @(negedge clk);
        check_frame(0, "b2b0", f_00, 10, -1, 1'b1, 8'h55);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        check_frame(0, "b2b1", f_55, 10, -1, 1'b0, 8'h00);
        @(negedge clk);
        check_outs(0, "b2b_post", 1'b1, 1'b0, 1'b0, 4'd0);

        // Even parity over 0x07 gives a parity bit of 1
        drive(1, 1'b1, 8'h07);
        @(negedge clk);
        check_frame(1, "par07", f_07p, 11, -1, 1'b0, 8'h00);
        @(negedge clk);
        check_outs(1, "par_post", 1'b1, 1'b0, 1'b0, 4'd0);

        // Reset during data bit 3 aborts without tx_done
        drive(0, 1'b1, 8'hA5);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        repeat (17) @(negedge clk);
        check_outs(0, "abort_pre", 1'b0, 1'b1, 1'b0, 4'd4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outs(0, "abort_rst", 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 3 * int'(BAUD); i++) begin
            @(negedge clk);
            check($sformatf("abort_nodone_%0d", i), 32'(done0), 32'd0);
            check($sformatf("abort_idle_%0d", i), 32'(busy0), 32'd0);
        end
        drive(0, 1'b1, 8'hA5);
        @(negedge clk);
        check_frame(0, "a5r", f_a5, 10, -1, 1'b0, 8'h00);
        @(negedge clk);
        check_outs(0, "a5r_post", 1'b1, 1'b0, 1'b0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
